// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants for the I2S transmitter slice.
//   DEFAULT_DATA_WIDTH / DEFAULT_SLOT_WIDTH : default sample and slot widths
//   LRCK_LEFT / LRCK_RIGHT                  : word-clock level for each slot
//   frame_bits(slot_width)                  : BCK periods per stereo frame
package i2s_pkg;

  localparam int DEFAULT_DATA_WIDTH = 24;
  localparam int DEFAULT_SLOT_WIDTH = 32;

  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  // A frame holds one left slot followed by one right slot.
  function automatic int frame_bits(input int slot_width);
    return 2 * slot_width;
  endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// i2s_bck_gen: divides the system clock down to the I2S bit clock.
//   clock    in   system clock, rising-edge logic
//   reset    in   synchronous active-high reset
//   bck      out  registered bit clock, BCK_DIV system clocks per half period
//   fall_stb out  high during the clock whose rising edge drives bck 1->0,
//                 so logic clocked on that same edge changes with the fall
module i2s_bck_gen
  import i2s_pkg::*;
#(
  parameter int BCK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  output logic bck,
  output logic fall_stb
);

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             bck_r;
  logic             tick_s;

  // Toggle point of the divider and the falling-edge strobe.
  always_comb begin
    tick_s   = (div_cnt_r == DIV_LAST);
    fall_stb = tick_s && bck_r;
  end

  // Divider counter and bit-clock register.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_r <= '0;
      bck_r     <= 1'b0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
      bck_r     <= ~bck_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  assign bck = bck_r;

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: parallel stereo PCM to I2S serializer.
//   clock        in   system clock, rising-edge logic
//   reset        in   synchronous active-high reset
//   left_data    in   left sample, two's complement
//   right_data   in   right sample, two's complement
//   sample_valid in   producer offers left_data/right_data
//   sample_ready out  one-entry holding buffer is empty
//   BCK          out  bit clock (registered)
//   LRCK         out  word clock, 0 = left slot, 1 = right slot (registered)
//   DATAOUT      out  serial data, MSB first, changes with BCK falls
//   underrun     out  one-clock pulse when a frame starts with no sample
// Build option: define I2S_TX_UNDERRUN_REPEAT_EN to repeat the previous
// frame on underrun; otherwise an underrun frame is digital silence.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SLOT_WIDTH = DEFAULT_SLOT_WIDTH,
  parameter int BCK_DIV    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic [DATA_WIDTH-1:0] right_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  BCK,
  output logic                  LRCK,
  output logic                  DATAOUT,
  output logic                  underrun
);

  localparam int FRAME_BITS = frame_bits(SLOT_WIDTH);
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int IDX_W      = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  logic                  bck_s;
  logic                  fall_stb_s;
  logic                  buf_full_r;
  logic [DATA_WIDTH-1:0] buf_left_r;
  logic [DATA_WIDTH-1:0] buf_right_r;
  logic [DATA_WIDTH-1:0] frame_left_r;
  logic [DATA_WIDTH-1:0] frame_right_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  lrck_r;
  logic                  dout_r;
  logic                  underrun_r;

  logic [CNT_W-1:0]      bit_next_s;
  logic                  frame_start_s;
  logic                  take_s;
  int                    b_int_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  lrck_next_s;
  logic                  dout_next_s;

  i2s_bck_gen #(
    .BCK_DIV(BCK_DIV)
  ) u_bck_gen (
    .clock   (clock),
    .reset   (reset),
    .bck     (bck_s),
    .fall_stb(fall_stb_s)
  );

  // Next frame position and the frame-start / handshake conditions.
  always_comb begin
    bit_next_s = '0;
    if (bit_cnt_r == CNT_LAST) begin
      bit_next_s = '0;
    end else begin
      bit_next_s = bit_cnt_r + CNT_W'(1);
    end
    frame_start_s = fall_stb_s && (bit_next_s == '0);
    take_s        = sample_valid && !buf_full_r;
  end

  // Word clock and serial bit for the position being entered. Position 0 of
  // each slot is the one-BCK I2S delay, so the MSB sits at position 1.
  always_comb begin
    b_int_s     = 32'(bit_next_s);
    idx_s       = '0;
    dout_next_s = 1'b0;
    lrck_next_s = (b_int_s >= SLOT_WIDTH) ? LRCK_RIGHT : LRCK_LEFT;
    if ((b_int_s >= 1) && (b_int_s <= DATA_WIDTH)) begin
      idx_s       = IDX_W'(DATA_WIDTH - b_int_s);
      dout_next_s = frame_left_r[idx_s];
    end else if ((b_int_s >= SLOT_WIDTH + 1) &&
                 (b_int_s <= SLOT_WIDTH + DATA_WIDTH)) begin
      idx_s       = IDX_W'(DATA_WIDTH - (b_int_s - SLOT_WIDTH));
      dout_next_s = frame_right_r[idx_s];
    end else begin
      dout_next_s = 1'b0;
    end
  end

  // One-entry holding buffer. A drain takes priority; since ready means
  // empty, a drain and a load never coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_full_r  <= 1'b0;
      buf_left_r  <= '0;
      buf_right_r <= '0;
    end else if (frame_start_s && buf_full_r) begin
      buf_full_r <= 1'b0;
    end else if (take_s) begin
      buf_full_r  <= 1'b1;
      buf_left_r  <= left_data;
      buf_right_r <= right_data;
    end
  end

  // Bit counter, serial outputs and frame registers. Frame registers only
  // change at frame start, so input changes mid-frame are harmless.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_r     <= CNT_LAST;
      lrck_r        <= LRCK_RIGHT;
      dout_r        <= 1'b0;
      underrun_r    <= 1'b0;
      frame_left_r  <= '0;
      frame_right_r <= '0;
    end else begin
      underrun_r <= 1'b0;
      if (fall_stb_s) begin
        bit_cnt_r <= bit_next_s;
        lrck_r    <= lrck_next_s;
        dout_r    <= dout_next_s;
      end
      if (frame_start_s) begin
        if (buf_full_r) begin
          frame_left_r  <= buf_left_r;
          frame_right_r <= buf_right_r;
        end else begin
          underrun_r <= 1'b1;
`ifndef I2S_TX_UNDERRUN_REPEAT_EN
          frame_left_r  <= '0;
          frame_right_r <= '0;
`endif
        end
      end
    end
  end

  assign sample_ready = !buf_full_r;
  assign BCK          = bck_s;
  assign LRCK         = lrck_r;
  assign DATAOUT      = dout_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: dut0 uses the defaults, dut1 the sweep
// (DATA_WIDTH=16, BCK_DIV=1). A timeline model derives every output from the
// number of clocks since reset release; a stream decoder recovers frames.
module tb_i2s_transmitter;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [1:0]  rst_v;
  logic [1:0]  valid_v;
  logic [23:0] l0, r0;
  logic [15:0] l1, r1;
  wire  [1:0]  ready_v, bck_v, lrck_v, dout_v, und_v;

  i2s_transmitter #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .BCK_DIV(2)) dut0 (
    .clock(clk), .reset(rst_v[0]), .left_data(l0), .right_data(r0),
    .sample_valid(valid_v[0]), .sample_ready(ready_v[0]), .BCK(bck_v[0]),
    .LRCK(lrck_v[0]), .DATAOUT(dout_v[0]), .underrun(und_v[0]));

  i2s_transmitter #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .BCK_DIV(1)) dut1 (
    .clock(clk), .reset(rst_v[1]), .left_data(l1), .right_data(r1),
    .sample_valid(valid_v[1]), .sample_ready(ready_v[1]), .BCK(bck_v[1]),
    .LRCK(lrck_v[1]), .DATAOUT(dout_v[1]), .underrun(und_v[1]));

  int total = 0;
  int bad   = 0;

  // ---------------- timeline model ----------------
  int          t_m[2];
  int          b_m[2];
  bit          full_m[2];
  logic [23:0] bl_m[2], br_m[2], fl_m[2], fr_m[2];
  bit          e_bck[2], e_lrck[2], e_dout[2], e_und[2];
  bit          mvalid[2];

  function automatic int dw_of(input int i);
    return (i == 0) ? 24 : 16;
  endfunction

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic bit bit_of(input logic [23:0] w, input int pos);
    logic [23:0] s;
    s = w >> pos;
    return s[0];
  endfunction

  task automatic model_step(input int i, input bit rst, input bit valid,
                            input logic [23:0] l, input logic [23:0] r);
    int d, dw, n, b;
    bit was_full, drain;
    d = div_of(i);
    dw = dw_of(i);
    mvalid[i] = 1'b1;
    if (rst) begin
      t_m[i] = 0; b_m[i] = 63; full_m[i] = 1'b0;
      bl_m[i] = '0; br_m[i] = '0; fl_m[i] = '0; fr_m[i] = '0;
      e_bck[i] = 1'b0; e_lrck[i] = 1'b1; e_dout[i] = 1'b0; e_und[i] = 1'b0;
      return;
    end
    was_full = full_m[i];
    drain = 1'b0;
    t_m[i] = t_m[i] + 1;
    e_und[i] = 1'b0;
    e_bck[i] = ((t_m[i] / d) % 2) == 1;
    if ((t_m[i] % (2 * d)) == 0) begin
      n = t_m[i] / (2 * d);
      b = (n + 63) % 64;
      b_m[i] = b;
      e_lrck[i] = (b >= 32);
      if (b == 0) begin
        if (was_full) begin
          fl_m[i] = bl_m[i]; fr_m[i] = br_m[i]; drain = 1'b1;
        end else begin
          e_und[i] = 1'b1;
`ifndef I2S_TX_UNDERRUN_REPEAT_EN
          fl_m[i] = '0; fr_m[i] = '0;
`endif
        end
      end
      if (b >= 1 && b <= dw) e_dout[i] = bit_of(fl_m[i], dw - b);
      else if (b >= 33 && b <= 32 + dw) e_dout[i] = bit_of(fr_m[i], dw - (b - 32));
      else e_dout[i] = 1'b0;
    end
    if (drain) full_m[i] = 1'b0;
    else if (valid && !was_full) begin
      bl_m[i] = l; br_m[i] = r; full_m[i] = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0, rst_v[0], valid_v[0], l0, r0);
      model_step(1, rst_v[1], valid_v[1], {8'h00, l1}, {8'h00, r1});
    end
  end

  // ---------------- compare + stream decoder ----------------
  bit          pb[2], plr[2], last_lr[2], have_l[2];
  int          pos[2];
  logic [23:0] word[2], dl[2];
  logic [47:0] fq0[$], fq1[$];
  int          lq0[$], bq0[$], bq1[$], uq0[$];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mvalid[i]) begin
          total++;
          if ({bck_v[i], lrck_v[i], dout_v[i], ready_v[i], und_v[i]} !==
              {e_bck[i], e_lrck[i], e_dout[i], !full_m[i], e_und[i]}) begin
            bad++;
            $display("FAIL cycle_compare dut%0d t=%0d bck/lrck/dout/ready/und got=%b%b%b%b%b expected=%b%b%b%b%b",
                     i, t_m[i], bck_v[i], lrck_v[i], dout_v[i], ready_v[i], und_v[i],
                     e_bck[i], e_lrck[i], e_dout[i], !full_m[i], e_und[i]);
          end
          if (t_m[i] == 0) begin
            pb[i] = 1'b0; plr[i] = 1'b1; last_lr[i] = 1'b1; have_l[i] = 1'b0;
            pos[i] = 0; word[i] = '0; dl[i] = '0;
          end else begin
            if (i == 0 && lrck_v[0] != plr[0]) lq0.push_back(t_m[0]);
            if (i == 0 && und_v[0]) uq0.push_back(t_m[0]);
            if (bck_v[i] && !pb[i]) begin
              if (i == 0) bq0.push_back(t_m[0]); else bq1.push_back(t_m[1]);
              if (lrck_v[i] != last_lr[i]) begin
                if (lrck_v[i]) begin
                  dl[i] = word[i]; have_l[i] = 1'b1;
                end else if (have_l[i]) begin
                  if (i == 0) fq0.push_back({dl[0], word[0]});
                  else fq1.push_back({dl[1], word[1]});
                  have_l[i] = 1'b0;
                end
                last_lr[i] = lrck_v[i]; pos[i] = 0; word[i] = '0;
              end else begin
                pos[i] = pos[i] + 1;
                if (pos[i] >= 1 && pos[i] <= dw_of(i)) word[i] = {word[i][22:0], dout_v[i]};
              end
            end
            pb[i] = bck_v[i]; plr[i] = lrck_v[i];
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? fq0.size() : fq1.size();
  endfunction

  task automatic wait_frames(input int i, input int target, input int maxc);
    int k;
    k = 0;
    while (qsize(i) < target && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (qsize(i) < target) begin
      total++; bad++;
      $display("FAIL timeout_frames dut%0d: got %0d frames expected %0d", i, qsize(i), target);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int k, s, j;
    bit rdy;
    logic [23:0] base, cnt;
    logic [47:0] exp2;
    rst_v = 2'b11; valid_v = 2'b00;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    repeat (3) @(negedge clk);

    // first sample offered right after reset release
    rst_v[0] = 1'b0; valid_v[0] = 1'b1; l0 = 24'hA5A5A5; r0 = 24'h123456;
    @(negedge clk);
    chk("ready_drop_after_accept", {63'd0, ready_v[0]}, 64'd0);
    valid_v[0] = 1'b0; l0 = 24'hDEAD00; r0 = 24'h00BEEF;
    k = 1;
    while (!ready_v[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_return_clock", 64'(k), 64'd4);

    // second frame has no sample: underrun
    wait_frames(0, 2, 900);
    chk("frame1_data", {16'd0, fq0[0]}, {16'd0, 24'hA5A5A5, 24'h123456});
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    exp2 = {24'hA5A5A5, 24'h123456};
`else
    exp2 = 48'd0;
`endif
    chk("frame2_underrun_data", {16'd0, fq0[1]}, {16'd0, exp2});
    chk("lrck_first_fall", 64'(lq0[0]), 64'd4);
    chk("lrck_first_rise", 64'(lq0[1]), 64'd132);
    chk("lrck_second_fall", 64'(lq0[2]), 64'd260);
    chk("bck_first_rise", 64'(bq0[0]), 64'd2);
    chk("bck_period", 64'(bq0[1] - bq0[0]), 64'd4);
    chk("underrun_first_pulse", 64'(uq0[0]), 64'd260);
    chk("underrun_next_pulse", 64'(uq0[1]), 64'd516);

    // back-pressure: valid held high, data advances on each accept
    s = fq0.size();
    base = 24'h000100; cnt = 24'd0;
    l0 = base; r0 = 24'h800000; valid_v[0] = 1'b1;
    k = 0;
    while (fq0.size() < s + 11 && k < 4000) begin
      rdy = ready_v[0];
      @(negedge clk);
      k++;
      if (rdy) begin
        cnt = cnt + 24'd1;
        l0 = base + cnt; r0 = 24'h800000 + cnt;
      end
    end
    if (fq0.size() < s + 11) begin
      total++; bad++;
      $display("FAIL timeout_backpressure: got %0d frames expected %0d", fq0.size(), s + 11);
    end
    j = s;
    for (int m = s + 2; m >= s; m--) if (fq0[m][47:24] == base) j = m;
    for (int m = 0; m < 8; m++)
      chk("backpressure_frame", {16'd0, fq0[j + m]},
          {16'd0, base + 24'(m), 24'h800000 + 24'(m)});

    // reset asserted at bit 10 of the left slot
    k = 0;
    while (!(b_m[0] == 10 && (t_m[0] % 4) == 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("reached_bit10", 64'(b_m[0]), 64'd10);
    rst_v[0] = 1'b1; valid_v[0] = 1'b0;
    @(negedge clk);
    chk("reset_state_bck_lrck_dout_ready",
        {60'd0, bck_v[0], lrck_v[0], dout_v[0], ready_v[0]}, 64'b0101);
    rst_v[0] = 1'b0; valid_v[0] = 1'b1; l0 = 24'h7FFFFF; r0 = 24'h800000;
    s = fq0.size();
    @(negedge clk);
    valid_v[0] = 1'b0;
    wait_frames(0, s + 1, 700);
    chk("restart_frame_data", {16'd0, fq0[s]}, {16'd0, 24'h7FFFFF, 24'h800000});

    // parameter sweep instance
    rst_v[1] = 1'b0; valid_v[1] = 1'b1; l1 = 16'h8001; r1 = 16'h1234;
    @(negedge clk);
    valid_v[1] = 1'b0;
    wait_frames(1, 1, 400);
    chk("sweep_frame_data", {16'd0, fq1[0]}, {16'd0, 24'h008001, 24'h001234});
    chk("sweep_bck_first_rise", 64'(bq1[0]), 64'd1);
    chk("sweep_bck_period", 64'(bq1[1] - bq1[0]), 64'd2);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
